// File: rtl/cfg_capture_pkg.sv
// Shared constants and helpers for the configuration-stream byte capture block.
package cfg_capture_pkg;

  localparam int unsigned CFG_BYTE_W  = 8;
  localparam int unsigned CFG_CNT_W   = 24;
  localparam int unsigned SYNC_STAGES = 2;

  localparam logic [CFG_CNT_W-1:0] CFG_CNT_MAX = {CFG_CNT_W{1'b1}};

  typedef logic [CFG_BYTE_W-1:0] cfg_byte_t;

  // Shift one serial bit into a partially assembled byte; after eight calls the
  // first bit sits in bit 7 (msb_first) or bit 0 (lsb first).
  function automatic cfg_byte_t shift_in(input cfg_byte_t cur, input logic bit_in,
                                         input logic msb_first);
    if (msb_first) begin
      return {cur[CFG_BYTE_W-2:0], bit_in};
    end else begin
      return {bit_in, cur[CFG_BYTE_W-1:1]};
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A write into a full FIFO is taken
// only when a read happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PtrW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic             do_rd;
  logic             do_wr;

  // Pointer-derived status and the accepted read/write strobes
  always_comb begin
    empty_o   = (wr_ptr_q == rd_ptr_q);
    full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd     = rd_en_i && !empty_o;
    do_wr     = wr_en_i && (!full_o || do_rd);
    rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Storage and pointers; storage is cleared so the head reads zero out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        wr_ptr_q                <= wr_ptr_q + PtrW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/cfg_byte_capture.sv
// Deserialises the loader's cfg_clk/cfg_dat stream into bytes, buffers them in a
// FIFO and presents them on a valid/ready interface with status counters/flags.
module cfg_byte_capture
  import cfg_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cfg_clk_i,
  input  logic                  cfg_dat_i,
  input  logic                  detached_i,
  output logic [CFG_BYTE_W-1:0] byte_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CFG_CNT_W-1:0]  byte_count_o,
  output logic                  overflow_o,
  output logic                  frame_err_o,
  output logic                  done_o
);

  // Edges are ignored until the synchronizers hold real samples, so an input
  // already high at reset release is not mistaken for a rising edge.
  localparam int unsigned        PrimeW   = $clog2(SYNC_STAGES + 2);
  localparam logic [PrimeW-1:0]  PrimeCyc = PrimeW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic [SYNC_STAGES-1:0] det_sync_q;
  logic                   clk_last_q;
  logic                   det_last_q;
  logic [PrimeW-1:0]      prime_cnt_q;
  logic                   primed;
  logic                   clk_rise;
  logic                   det_rise;

  logic                   edge_q;
  logic                   bit_q;
  logic [2:0]             bit_cnt_q;
  cfg_byte_t              shreg_q;
  logic                   push_q;

  logic [CFG_CNT_W-1:0]   byte_count_q;
  logic                   overflow_q;
  logic                   frame_err_q;
  logic                   done_q;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   push_ok;

  // Input synchronizers, edge-detect history and post-reset priming counter
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      clk_sync_q  <= '0;
      dat_sync_q  <= '0;
      det_sync_q  <= '0;
      clk_last_q  <= 1'b0;
      det_last_q  <= 1'b0;
      prime_cnt_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], cfg_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], cfg_dat_i};
      det_sync_q <= {det_sync_q[SYNC_STAGES-2:0], detached_i};
      clk_last_q <= clk_sync_q[SYNC_STAGES-1];
      det_last_q <= det_sync_q[SYNC_STAGES-1];
      if (!primed) begin
        prime_cnt_q <= prime_cnt_q + PrimeW'(1);
      end
    end
  end

  // Rising-edge detection and FIFO handshake decode
  always_comb begin
    primed   = (prime_cnt_q == PrimeCyc);
    clk_rise = primed && clk_sync_q[SYNC_STAGES-1] && !clk_last_q;
    det_rise = primed && det_sync_q[SYNC_STAGES-1] && !det_last_q;
    valid_o  = !fifo_empty;
    pop      = valid_o && ready_i;
    push_ok  = push_q && (!fifo_full || pop);
  end

  // Register the edge strobe together with its data bit before the shifter
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      edge_q <= 1'b0;
      bit_q  <= 1'b0;
    end else begin
      edge_q <= clk_rise;
      bit_q  <= dat_sync_q[SYNC_STAGES-1];
    end
  end

  // Shifter and bit counter; a detach drops any partial byte
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      push_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (det_rise) begin
        bit_cnt_q <= '0;
      end else if (edge_q) begin
        shreg_q   <= shift_in(shreg_q, bit_q, MSB_FIRST);
        bit_cnt_q <= bit_cnt_q + 3'd1;
        push_q    <= (bit_cnt_q == 3'd7);
      end
    end
  end

  // Saturating accepted-byte counter and sticky status flags
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      byte_count_q <= '0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (push_ok && (byte_count_q != CFG_CNT_MAX)) begin
        byte_count_q <= byte_count_q + CFG_CNT_W'(1);
      end
      if (push_q && !push_ok) begin
        overflow_q <= 1'b1;
      end
      if (det_rise) begin
        done_q <= 1'b1;
        if (bit_cnt_q != 3'd0) begin
          frame_err_q <= 1'b1;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (CFG_BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (reset_i),
    .wr_en_i   (push_ok),
    .wr_data_i (shreg_q),
    .rd_en_i   (pop),
    .rd_data_o (byte_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign byte_count_o = byte_count_q;
  assign overflow_o   = overflow_q;
  assign frame_err_o  = frame_err_q;
  assign done_o       = done_q;

endmodule

// File: doc/cfg_byte_capture.md
# cfg_byte_capture

Deserialises the serial configuration stream (`cfg_clk`/`cfg_dat`) produced by the SD-card loader `chip` into bytes. It buffers the bytes in a small FIFO and presents them on a valid/ready byte interface. It sits directly downstream of `chip` and replaces the ad-hoc LED shift register in the top level. Its consumers are a UART transmitter (for dumping over `usb_rx`) or a checksum stage.

## Interface
Parameters:
- `FIFO_DEPTH`, 16, byte FIFO entries; power of two, ≥2
- `MSB_FIRST`, 1, 1: first received bit lands in bit 7; 0: first received bit lands in bit 0

Ports:
- `clk_i`  in  1  system clock (clk50M)
- `reset_i`  in  1  reset, asynchronous, active-low
- `cfg_clk_i`  in  1  serial bit clock from the loader; data valid on its rising edge
- `cfg_dat_i`  in  1  serial data from the loader
- `detached_i`  in  1  loader finished/detached; a rising edge ends the stream
- `byte_o`  out  8  FIFO head byte
- `valid_o`  out  1  `byte_o` valid (FIFO non-empty)
- `ready_i`  in  1  consumer accepts `byte_o`
- `byte_count_o`  out  24  bytes accepted into the FIFO, saturating at 0xFFFFFF
- `overflow_o`  out  1  sticky: a byte was dropped because the FIFO was full
- `frame_err_o`  out  1  sticky: stream ended with a partial byte
- `done_o`  out  1  sticky: `detached_i` rising edge seen

## Operation
- `cfg_clk_i` and `cfg_dat_i` each pass through a 2-flop synchronizer. A third register on the clock path detects a 0→1 transition.
- On a detected rising edge, the synchronized data bit shifts into the shift register. The direction is set by `MSB_FIRST`. The 3-bit bit counter then increments.
- When the bit counter wraps from 7 to 0, the assembled byte is pushed to the FIFO on the next cycle.
- Push when the FIFO is full and there is no pop in the same cycle:
  - the byte is dropped;
  - `overflow_o` is set;
  - `byte_count_o` does not increment.
- Push when the FIFO is full and a pop occurs in the same cycle: the push is accepted.
- Pop occurs when `valid_o && ready_i`. `byte_o` stays stable while `valid_o && !ready_i`.
- On a `detached_i` rising edge (input synchronized the same way):
  - `done_o` is set;
  - if the bit counter ≠ 0, `frame_err_o` is set, the partial byte is discarded, and the bit counter clears;
  - the FIFO keeps draining normally.
- `cfg_clk_i` edges after `done_o` are still captured. There is no lockout, because the loader may restart.
- The sticky flags clear only on reset.

## Timing
- Reset values:
  - `byte_o`=0x00, `valid_o`=0, `byte_count_o`=0;
  - `overflow_o`=0, `frame_err_o`=0, `done_o`=0;
  - bit counter=0, FIFO empty.
- The reset synchronizer flops also clear to 0. A `cfg_clk_i` that is high at reset release does not produce an edge.
- `cfg_clk_i` high and low phases must each be ≥2 `clk_i` cycles. Faster input is unsupported and unchecked.
- Latency: if the 8th bit's `cfg_clk_i` is first sampled high at clk edge N and the FIFO is empty, then `valid_o`=1 and the byte appears on `byte_o` at edge N+4. `byte_count_o` updates at the same edge.
- Throughput: one pop per cycle while the FIFO is non-empty.
- `valid_o` falls on the edge after the last pop.
- Reset asserted mid-byte or mid-drain: all state clears immediately (asynchronous). No byte is emitted after release until 8 new bits arrive.

## Structure
- Package `cfg_capture_pkg`:
  - `CFG_BYTE_W`=8;
  - `CFG_CNT_W`=24;
  - `SYNC_STAGES`=2.
- One sub-module, `sync_fifo`: parameterised width/depth, single clock, async active-low reset, `full`/`empty`, first-word-fall-through output.
- Top-level logic (synchronizers, edge detect, shifter, counters, flags) stays in `cfg_byte_capture`.

## Test plan
- Send 0xA5 then 0x3C, MSB-first, with 4-cycle high/low bit phases and `ready_i`=1:
  - `byte_o` shows 0xA5 then 0x3C, each for exactly one cycle;
  - first `valid_o` at 8th-edge+4;
  - `byte_count_o`=2.
- Set `MSB_FIRST`=0 and send bits 1,0,0,0,0,0,0,0 → byte 0x01.
- Hold `ready_i`=0 and send FIFO_DEPTH+1 bytes (0x00..0x10):
  - FIFO holds 0x00..0x0F;
  - `overflow_o`=1;
  - `byte_count_o`=16;
  - draining yields 0x00..0x0F in order.
- FIFO full with `ready_i` pulsed on the exact cycle the 17th byte pushes → no overflow, `byte_count_o`=17.
- Send 5 bits, then raise `detached_i`:
  - `frame_err_o`=1, `done_o`=1, no byte emitted;
  - a following full byte 0xFF is captured correctly.
- Assert `reset_i`=0 after 3 bits of a byte with 2 bytes queued:
  - all outputs return to reset values immediately;
  - after release, 8 bits of 0x5A → exactly one byte, 0x5A.
